trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of external interrupt channels (1..14).
REQ-002 Parameter DEPTH, default 2, maximum trap nesting depth (1..7).
REQ-003 Parameter AW, default 16, vector width.
REQ-004 Parameter IVEC, default 16'h4, vector base address.
REQ-005 Parameter VSTRIDE, default 16'h0, vector spacing; 0 makes all traps share IVEC.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 irq_in  input  NCH  level interrupt requests; rising edge latches a pending bit.
REQ-009 fault_in  input  1  page-fault request, non-maskable.
REQ-010 syscall  input  1  one-cycle software trap request.
REQ-011 irq_en  input  1  global interrupt enable (control-register bit 3).
REQ-012 mask  input  NCH  per-channel enable; 1 = enabled.
REQ-013 boundary  input  1  CPU is at an instruction boundary (FETCH).
REQ-014 ack  input  1  CPU has accepted the presented trap.
REQ-015 reti  input  1  one-cycle return-from-trap.
REQ-016 take  output  1  trap presented; held until ack.
REQ-017 trapnr  output  4  0 = fault, 1 = syscall, 2+i = irq channel i.
REQ-018 vector  output  AW  IVEC + trapnr*VSTRIDE, modulo 2^AW.
REQ-019 bank  output  3  current nesting depth; 0 = user bank.
REQ-020 replay  output  1  high with take when trapnr = 0; CPU rewinds PC by 2.
REQ-021 pending  output  NCH  latched irq pending bits.
REQ-022 dfault  output  1  sticky double-fault/halt indication.

Function
REQ-023 Pending irq bit i SHALL set on the posedge where irq_in[i] is 1 and was 0 the previous cycle; it clears only on ack of trap 2+i or on reset.
REQ-024 The fault latch SHALL set on any cycle with fault_in = 1; the syscall latch SHALL set on any cycle with syscall = 1; each clears on ack of its own trap.
REQ-025 Eligibility SHALL be: fault always; syscall always; irq i only if pending[i], mask[i], irq_en and bank = 0.
REQ-026 Priority SHALL be fault > syscall > lowest-numbered eligible irq.
REQ-027 The FSM SHALL have the states IDLE, PRESENT and HALT.
REQ-028 IDLE -> PRESENT SHALL occur on a posedge with boundary = 1, reti = 0, bank < DEPTH and at least one eligible trap; take, trapnr, vector and replay register on that edge (1-cycle latency from the boundary sample).
REQ-029 In PRESENT, take, trapnr and vector SHALL stay stable regardless of new requests until ack = 1.
REQ-030 On ack in PRESENT: bank increments, the serviced latch clears, and take drops the next cycle (return to IDLE).
REQ-031 In IDLE, reti with bank > 0 SHALL decrement bank; reti with bank = 0 SHALL be ignored.
REQ-032 reti and an eligible trap in the same cycle: reti SHALL be applied, and arbitration SHALL be deferred to the next boundary.
REQ-033 reti in PRESENT SHALL be ignored.
REQ-034 A fault or syscall eligible at boundary with bank = DEPTH SHALL enter HALT and set dfault; irqs at bank = DEPTH are simply held pending.
REQ-035 HALT SHALL be left only by reset; in HALT, take = 0 and latches keep accumulating.
REQ-036 ack outside PRESENT SHALL be ignored.
REQ-037 A rising edge and an ack clear of the same irq bit in one cycle: the set SHALL win.

Reset
REQ-038 On reset: state IDLE; take, replay, dfault = 0; trapnr = 0; vector = IVEC; bank = 0; all pending, fault and syscall latches = 0; edge-detect history = 0.
REQ-039 Reset asserted in PRESENT SHALL abort the trap without a bank change.

Verification
REQ-040 NCH=4, VSTRIDE=8: irq_in[2] rises, irq_en=1, mask=4'hF, boundary=1 -> take 2 cycles after the edge, trapnr=4, vector=16'h24; ack -> bank=1, pending=0.
REQ-041 fault_in, syscall and irq_in[0] all in the same cycle -> trapnr=0, replay=1 first; after ack and the next boundary, trapnr=1; irq0 is held pending while bank > 0.
REQ-042 DEPTH=2: take and ack two syscalls (bank=2), then fault_in at boundary -> dfault=1, take stays 0 until reset.
REQ-043 At bank=1, reti coincides with an eligible syscall at boundary -> bank=0 that cycle, take rises only at the following boundary.
REQ-044 mask[1]=0, irq_in[1] rises -> pending[1]=1, no take; mask[1] set to 1 -> take with trapnr=3 at the next boundary.
REQ-045 reset during PRESENT -> next cycle take=0, bank unchanged at 0, pending cleared.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: prioritised fault/syscall/irq trap controller with nesting banks.
// Presents one trap at a time and holds it until ack; halts on traps beyond DEPTH.
module trap_ctrl #(
    parameter int              NCH     = 4,
    parameter int              DEPTH   = 2,
    parameter int              AW      = 16,
    parameter logic [AW-1:0]   IVEC    = AW'(4),
    parameter logic [AW-1:0]   VSTRIDE = AW'(0)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] irq_in,
    input  logic           fault_in,
    input  logic           syscall,
    input  logic           irq_en,
    input  logic [NCH-1:0] mask,
    input  logic           boundary,
    input  logic           ack,
    input  logic           reti,
    output logic           take,
    output logic [3:0]     trapnr,
    output logic [AW-1:0]  vector,
    output logic [2:0]     bank,
    output logic           replay,
    output logic [NCH-1:0] pending,
    output logic           dfault
);
    typedef enum logic [1:0] {IDLE, PRESENT, HALT} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] prev_q, pend_q, pend_d, elig, clr_irq;
    logic           fault_q, fault_d, sys_q, sys_d, dfault_q, dfault_d;
    logic [2:0]     bank_q, bank_d;
    logic [3:0]     nr_q, nr_d, sel;
    logic [AW-1:0]  vec_q, vec_d;
    logic           acked;

    assign acked = state_q == PRESENT && ack;
    // irqs only compete while running in the user bank
    assign elig  = pend_q & mask & {NCH{irq_en && bank_q == 3'd0}};

    always_comb begin
        sel     = 4'd0;
        clr_irq = '0;
        for (int i = 0; i < NCH; i++) begin
            if (elig[i] && sel == 4'd0) sel = 4'(i + 2);
            clr_irq[i] = acked && nr_q == 4'(i + 2);
        end
    end

    // a new request in the same cycle as its ack clear wins
    assign pend_d  = (irq_in & ~prev_q) | (pend_q & ~clr_irq);
    assign fault_d = fault_in | (fault_q & ~(acked && nr_q == 4'd0));
    assign sys_d   = syscall | (sys_q & ~(acked && nr_q == 4'd1));

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        nr_d     = nr_q;
        vec_d    = vec_q;
        dfault_d = dfault_q;
        case (state_q)
            IDLE: begin
                if (reti)
                    bank_d = (bank_q != 3'd0) ? bank_q - 3'd1 : bank_q;
                else if (boundary && (fault_q || sys_q || |elig)) begin
                    if (bank_q < 3'(DEPTH)) begin
                        state_d = PRESENT;
                        nr_d    = fault_q ? 4'd0 : sys_q ? 4'd1 : sel;
                        vec_d   = IVEC + AW'(nr_d) * VSTRIDE;
                    end else if (fault_q || sys_q) begin
                        state_d  = HALT;
                        dfault_d = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = IDLE;
                    bank_d  = bank_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            pend_q   <= '0;
            fault_q  <= 1'b0;
            sys_q    <= 1'b0;
            dfault_q <= 1'b0;
            bank_q   <= 3'd0;
            nr_q     <= 4'd0;
            vec_q    <= IVEC;
        end else begin
            state_q  <= state_d;
            prev_q   <= irq_in;
            pend_q   <= pend_d;
            fault_q  <= fault_d;
            sys_q    <= sys_d;
            dfault_q <= dfault_d;
            bank_q   <= bank_d;
            nr_q     <= nr_d;
            vec_q    <= vec_d;
        end
    end

    assign take    = state_q == PRESENT;
    assign replay  = take && nr_q == 4'd0;
    assign trapnr  = nr_q;
    assign vector  = vec_q;
    assign bank    = bank_q;
    assign pending = pend_q;
    assign dfault  = dfault_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus for trap_ctrl, checked every cycle against a
// rule-level model plus hand-computed literal expectations.
module tb_trap_ctrl;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset, fault_in, syscall, irq_en, boundary, ack, reti;
    logic [3:0] irq_in, mask;
    logic       take, replay, dfault;
    logic [3:0] trapnr, pending;
    logic [15:0] vector;
    logic [2:0] bank;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    trap_ctrl #(.NCH(4), .DEPTH(DEPTH), .AW(16), .IVEC(16'h4), .VSTRIDE(16'h8)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .fault_in(fault_in), .syscall(syscall),
        .irq_en(irq_en), .mask(mask), .boundary(boundary), .ack(ack), .reti(reti),
        .take(take), .trapnr(trapnr), .vector(vector), .bank(bank), .replay(replay),
        .pending(pending), .dfault(dfault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       take, halt, df, f, s;
        logic [3:0] nr;
        logic [2:0] bank;
        logic [3:0] pend, prev;
    } mst_t;

    mst_t m;

    function automatic mst_t next_model(mst_t c);
        mst_t       n    = c;
        logic [3:0] rise = irq_in & ~c.prev;
        logic       done = c.take && ack;
        int         win  = -1;
        if (c.take) begin
            if (ack) begin
                n.take = 1'b0;
                n.bank = 3'(c.bank + 1);
            end
        end else if (!c.halt && reti) begin
            if (c.bank > 0) n.bank = 3'(c.bank - 1);
        end else if (!c.halt && boundary) begin
            if (c.f) win = 0;
            else if (c.s) win = 1;
            else if (c.bank == 0 && irq_en)
                for (int i = 3; i >= 0; i--) if (c.pend[i] && mask[i]) win = i + 2;
            if (win >= 0 && c.bank < DEPTH) begin
                n.take = 1'b1;
                n.nr   = 4'(win);
            end else if (win == 0 || win == 1) begin
                n.halt = 1'b1;
                n.df   = 1'b1;
            end
        end
        n.f = fault_in || (c.f && !(done && c.nr == 0));
        n.s = syscall || (c.s && !(done && c.nr == 1));
        for (int i = 0; i < 4; i++) n.pend[i] = rise[i] || (c.pend[i] && !(done && c.nr == 4'(i + 2)));
        n.prev = irq_in;
        return n;
    endfunction

    always @(posedge clk) m <= reset ? '0 : next_model(m);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (armed) begin
        chk("model take", 32'(take), 32'(m.take));
        chk("model trapnr", 32'(trapnr), 32'(m.nr));
        chk("model vector", 32'(vector), 32'(16'(16'h4 + m.nr * 16'h8)));
        chk("model bank", 32'(bank), 32'(m.bank));
        chk("model replay", 32'(replay), 32'(m.take && m.nr == 0));
        chk("model pending", 32'(pending), 32'(m.pend));
        chk("model dfault", 32'(dfault), 32'(m.df));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1; irq_in = 0; fault_in = 0; syscall = 0; irq_en = 1; mask = 4'hF;
        boundary = 0; ack = 0; reti = 0;
        repeat (2) cyc();
        reset = 0; armed = 1;
        chk("reset take", 32'(take), 0);
        chk("reset trapnr", 32'(trapnr), 0);
        chk("reset vector", 32'(vector), 32'h4);
        chk("reset bank", 32'(bank), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset dfault", 32'(dfault), 0);

        // irq2 edge, then a syscall arriving while presenting
        irq_in = 4'b0100; boundary = 1;
        cyc(); chk("irq2 pending", 32'(pending), 32'h4); chk("irq2 no take yet", 32'(take), 0);
        cyc(); chk("irq2 take", 32'(take), 1); chk("irq2 trapnr", 32'(trapnr), 4);
        chk("irq2 vector", 32'(vector), 32'h24); chk("irq2 replay", 32'(replay), 0);
        syscall = 1;
        cyc(); syscall = 0; chk("irq2 stable", 32'(trapnr), 4); ack = 1; boundary = 0;
        cyc(); ack = 0; chk("irq2 ack take", 32'(take), 0); chk("irq2 ack bank", 32'(bank), 1);
        chk("irq2 ack pending", 32'(pending), 0); boundary = 1;
        cyc(); chk("sys take", 32'(take), 1); chk("sys trapnr", 32'(trapnr), 1);
        chk("sys vector", 32'(vector), 32'hC); ack = 1; boundary = 0;
        cyc(); ack = 0; chk("bank2", 32'(bank), 2); reti = 1;
        cyc(); chk("reti bank1", 32'(bank), 1);
        cyc(); reti = 0; chk("reti bank0", 32'(bank), 0); irq_in = 0; reti = 1;
        cyc(); reti = 0; chk("reti at bank0 ignored", 32'(bank), 0);

        // fault, syscall and irq0 together
        fault_in = 1; syscall = 1; irq_in = 4'b0001; boundary = 1;
        cyc(); fault_in = 0; syscall = 0; chk("triple no take", 32'(take), 0);
        cyc(); chk("fault trapnr", 32'(trapnr), 0); chk("fault replay", 32'(replay), 1);
        chk("fault vector", 32'(vector), 32'h4); ack = 1; boundary = 0;
        cyc(); ack = 0; boundary = 1; chk("fault bank", 32'(bank), 1);
        cyc(); chk("then sys trapnr", 32'(trapnr), 1); chk("then sys replay", 32'(replay), 0);
        ack = 1; boundary = 0;
        cyc(); ack = 0; chk("irq0 held", 32'(pending), 32'h1); chk("irq0 held take", 32'(take), 0);
        reti = 1;
        cyc();
        cyc(); reti = 0; boundary = 1;
        cyc(); chk("irq0 trapnr", 32'(trapnr), 2); chk("irq0 vector", 32'(vector), 32'h14);
        irq_in = 0;
        cyc(); irq_in = 4'b0001; ack = 1; boundary = 0;
        cyc(); ack = 0; chk("set beats clear", 32'(pending), 32'h1); reti = 1;
        cyc(); reti = 0; boundary = 1;
        cyc(); chk("irq0 again", 32'(trapnr), 2); ack = 1; boundary = 0;
        cyc(); ack = 0; chk("irq0 cleared", 32'(pending), 0); reti = 1; irq_in = 0;
        cyc(); reti = 0;

        // reti coinciding with an eligible syscall
        syscall = 1; boundary = 1;
        cyc(); syscall = 0;
        cyc(); chk("d sys take", 32'(take), 1); ack = 1; boundary = 0;
        cyc(); ack = 0; chk("d bank1", 32'(bank), 1); syscall = 1;
        cyc(); syscall = 0; reti = 1; boundary = 1;
        cyc(); reti = 0; chk("reti wins bank", 32'(bank), 0); chk("reti defers take", 32'(take), 0);
        cyc(); chk("deferred take", 32'(take), 1); chk("deferred trapnr", 32'(trapnr), 1);
        ack = 1; boundary = 0;
        cyc(); ack = 0; reti = 1;
        cyc(); reti = 0; ack = 1;
        cyc(); ack = 0; chk("idle ack ignored", 32'(bank), 0);

        // masked irq1
        mask = 4'b1101; irq_in = 4'b0010; boundary = 1;
        cyc(); chk("masked pending", 32'(pending), 32'h2);
        cyc(); chk("masked no take", 32'(take), 0); mask = 4'hF;
        cyc(); chk("unmask trapnr", 32'(trapnr), 3); chk("unmask vector", 32'(vector), 32'h1C);
        ack = 1; boundary = 0; irq_in = 0;
        cyc(); ack = 0; reti = 1;
        cyc(); reti = 0;

        // reset while presenting
        irq_in = 4'b1000; boundary = 1;
        cyc();
        cyc(); chk("irq3 trapnr", 32'(trapnr), 5); chk("irq3 vector", 32'(vector), 32'h2C);
        reset = 1; irq_in = 0;
        cyc(); reset = 0; chk("abort take", 32'(take), 0); chk("abort bank", 32'(bank), 0);
        chk("abort pending", 32'(pending), 0);

        // double fault
        syscall = 1; boundary = 1;
        cyc(); syscall = 0;
        cyc(); ack = 1; boundary = 0;
        cyc(); ack = 0; syscall = 1; boundary = 1;
        cyc(); syscall = 0;
        cyc(); ack = 1; boundary = 0;
        cyc(); ack = 0; chk("depth bank", 32'(bank), 2); fault_in = 1; boundary = 1;
        cyc(); fault_in = 0;
        cyc(); chk("halt dfault", 32'(dfault), 1); chk("halt take", 32'(take), 0);
        for (int k = 0; k < 4; k++) begin
            syscall = 1; ack = 1; reti = k[0]; irq_in = k[0] ? 4'h3 : 4'h0;
            cyc();
            chk("halt stays", 32'({take, dfault, bank}), 32'({1'b0, 1'b1, 3'd2}));
        end
        syscall = 0; ack = 0; reti = 0; irq_in = 0; reset = 1;
        cyc(); reset = 0; chk("halt reset dfault", 32'(dfault), 0); chk("halt reset bank", 32'(bank), 0);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
